// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} div_state_t;

  localparam int                   DIV_WIDTH  = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  // 0x80000000 maps to itself and is then read as an unsigned magnitude.
  function automatic logic [DIV_WIDTH-1:0] abs32(input logic [DIV_WIDTH-1:0] value,
                                                 input logic                 sign);
    return (sign && value[DIV_WIDTH-1]) ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Start/result handshake between the ALU stage (master) and the divider (slave).
interface div_seq_if #(parameter int WIDTH = 32);

  logic             validIn;
  logic             sign;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             validOut;
  logic             busy;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (output validIn, sign, SrcA, SrcB,
                  input  validOut, busy, Hi, Lo);

  modport slave  (input  validIn, sign, SrcA, SrcB,
                  output validOut, busy, Hi, Lo);

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // Two spare bits keep the shifted remainder and the compare carry intact.
  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] dvs_ext;
  logic             ge;

  assign sh      = {rem_i, quo_i[WIDTH-1]};
  assign dvs_ext = {2'b00, dvs_i};
  assign ge      = (sh >= dvs_ext);

  assign rem_o = ge ? (WIDTH+1)'(sh - dvs_ext) : (WIDTH+1)'(sh);
  assign quo_o = {quo_i[WIDTH-2:0], ge};

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU: Lo = quotient, Hi = remainder.
// Optional macro DIV_EARLY_TERM_EN skips iterations for zero divisor or |dividend| < |divisor|.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      reset,
  div_seq_if.slave  bus
);

  div_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH:0]    rem_q;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH-1:0]  dvs_q;
  logic              negq_q;
  logic              negr_q;
  logic              valid_q;
  logic              busy_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;

  logic [WIDTH:0]    rem_d;
  logic [WIDTH-1:0]  quo_d;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;

  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] mag,
                                                input logic             neg);
    logic signed [WIDTH-1:0] m;
    m = mag;
    return neg ? -m : m;
  endfunction

  assign mag_a = abs32(bus.SrcA, bus.sign);
  assign mag_b = abs32(bus.SrcB, bus.sign);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        // Start: latch magnitudes and result signs.
        IDLE: begin
          if (bus.validIn) begin
            rem_q   <= '0;
            quo_q   <= mag_a;
            dvs_q   <= mag_b;
            // Zero divisor keeps the all-ones quotient unsigned.
            negq_q  <= bus.sign & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]) & (|bus.SrcB);
            negr_q  <= bus.sign & bus.SrcA[WIDTH-1];
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= BUSY;
`ifdef DIV_EARLY_TERM_EN
            if (bus.SrcB == '0) begin
              rem_q   <= {1'b0, bus.SrcA};
              quo_q   <= DIV_ZERO_Q;
              negq_q  <= 1'b0;
              negr_q  <= 1'b0;
              state_q <= FIX;
            end else if (mag_a < mag_b) begin
              rem_q   <= {1'b0, mag_a};
              quo_q   <= '0;
              state_q <= FIX;
            end
`endif
          end
        end
        // Iterate: one quotient bit per edge; dropping validIn aborts.
        BUSY: begin
          if (!bus.validIn) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_q <= FIX;
            end
          end
        end
        // Sign-correct and publish the result.
        FIX: begin
          lo_q    <= fix_sign(quo_q, negq_q);
          hi_q    <= fix_sign(rem_q[WIDTH-1:0], negr_q);
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.validOut = valid_q;
  assign bus.busy     = busy_q;
  assign bus.Hi       = hi_q;
  assign bus.Lo       = lo_q;

endmodule
